// File: rtl/trace_event_counter_bank.sv
// Programmable performance-counter bank fed by the per-cycle trace event vector.
// Each counter counts cycles in which its selected event bit was high; it also provides shadow snapshots, a registered read port and sticky overflow.
module trace_event_counter_bank #(
  parameter  int NUM_COUNTERS = 4,
  parameter  int COUNTER_W    = 40,
  parameter  int EVENT_W      = 33,
  parameter  int SEL_W        = $clog2(EVENT_W),
  localparam int IDX_W        = (NUM_COUNTERS > 1) ? $clog2(NUM_COUNTERS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [EVENT_W-1:0]      events,
  input  logic                    global_en,
  input  logic                    cfg_wr,
  input  logic [IDX_W-1:0]        cfg_idx,
  input  logic [SEL_W-1:0]        cfg_sel,
  input  logic                    cfg_en,
  input  logic                    cfg_clear,
  input  logic                    snapshot_req,
  input  logic                    rd_req,
  input  logic [IDX_W-1:0]        rd_idx,
  input  logic                    rd_shadow,
  output logic                    rd_valid,
  output logic [COUNTER_W-1:0]    rd_data,
  output logic [NUM_COUNTERS-1:0] overflow,
  output logic                    overflow_irq
);

  localparam int EV_PAD = 1 << SEL_W;

  logic [EVENT_W-1:0]      r_ev_q;
  logic                    r_gen_q;
  logic [COUNTER_W-1:0]    r_cnt [NUM_COUNTERS];
  logic [COUNTER_W-1:0]    r_shd [NUM_COUNTERS];
  logic [SEL_W-1:0]        r_sel [NUM_COUNTERS];
  logic [NUM_COUNTERS-1:0] r_en;
  logic [NUM_COUNTERS-1:0] r_ovf;
  logic                    r_irq;
  logic                    r_rd_valid;
  logic [COUNTER_W-1:0]    r_rd_data;

  logic [EV_PAD-1:0]       w_ev_pad;
  logic [NUM_COUNTERS-1:0] w_inc;
  logic [NUM_COUNTERS-1:0] w_cfg_hit;
  logic [COUNTER_W-1:0]    w_rd_val;

  // Padding to the full select range makes out-of-range selects read as 0.
  assign w_ev_pad = EV_PAD'(r_ev_q);

  always_comb begin
    w_inc     = '0;
    w_cfg_hit = '0;
    for (int k = 0; k < NUM_COUNTERS; k++) begin
      w_cfg_hit[k] = cfg_wr && (cfg_idx == IDX_W'(k));
      w_inc[k]     = r_gen_q && r_en[k] && (int'(r_sel[k]) < EVENT_W) && w_ev_pad[r_sel[k]];
    end
  end

  always_comb begin
    w_rd_val = '0;
    for (int k = 0; k < NUM_COUNTERS; k++) begin
      if (rd_idx == IDX_W'(k)) w_rd_val = rd_shadow ? r_shd[k] : r_cnt[k];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_ev_q     <= '0;
      r_gen_q    <= 1'b0;
      r_en       <= '0;
      r_ovf      <= '0;
      r_irq      <= 1'b0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      for (int k = 0; k < NUM_COUNTERS; k++) begin
        r_cnt[k] <= '0;
        r_shd[k] <= '0;
        r_sel[k] <= '0;
      end
    end else begin
      r_ev_q  <= events;
      r_gen_q <= global_en;
      for (int k = 0; k < NUM_COUNTERS; k++) begin
        if (snapshot_req) r_shd[k] <= r_cnt[k];
        if (w_cfg_hit[k]) begin
          r_sel[k] <= cfg_sel;
          r_en[k]  <= cfg_en;
        end
        // A clear beats both a same-cycle increment and a same-cycle wrap.
        if (w_cfg_hit[k] && cfg_clear) begin
          r_cnt[k] <= '0;
          r_ovf[k] <= 1'b0;
        end else if (w_inc[k]) begin
          r_cnt[k] <= r_cnt[k] + 1'b1;
          if (&r_cnt[k]) r_ovf[k] <= 1'b1;
        end
      end
      r_irq      <= |(r_ovf & r_en);
      r_rd_valid <= rd_req;
      if (rd_req) r_rd_data <= w_rd_val;
    end
  end

  assign rd_valid     = r_rd_valid;
  assign rd_data      = r_rd_data;
  assign overflow     = r_ovf;
  assign overflow_irq = r_irq;

endmodule

// File: tb/tb_trace_event_counter_bank.sv
// Directed bench for trace_event_counter_bank with 8-bit counters so the wrap path is reachable.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_trace_event_counter_bank;

  localparam int NC     = 4;
  localparam int CW     = 8;
  localparam int EW     = 33;
  localparam int SW     = 6;
  localparam int IW     = 2;
  localparam int EV_ALU = 5;

  logic          clk;
  logic          rst;
  logic [EW-1:0] events;
  logic          global_en;
  logic          cfg_wr;
  logic [IW-1:0] cfg_idx;
  logic [SW-1:0] cfg_sel;
  logic          cfg_en;
  logic          cfg_clear;
  logic          snapshot_req;
  logic          rd_req;
  logic [IW-1:0] rd_idx;
  logic          rd_shadow;
  logic          rd_valid;
  logic [CW-1:0] rd_data;
  logic [NC-1:0] overflow;
  logic          overflow_irq;

  int n_chk = 0;
  int n_err = 0;

  trace_event_counter_bank #(
    .NUM_COUNTERS(NC), .COUNTER_W(CW), .EVENT_W(EW), .SEL_W(SW)
  ) dut (
    .clk(clk), .rst(rst), .events(events), .global_en(global_en),
    .cfg_wr(cfg_wr), .cfg_idx(cfg_idx), .cfg_sel(cfg_sel), .cfg_en(cfg_en),
    .cfg_clear(cfg_clear), .snapshot_req(snapshot_req), .rd_req(rd_req),
    .rd_idx(rd_idx), .rd_shadow(rd_shadow), .rd_valid(rd_valid),
    .rd_data(rd_data), .overflow(overflow), .overflow_irq(overflow_irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic cfg(input int idx, input int sel, input logic en, input logic clr);
    cfg_wr = 1'b1; cfg_idx = IW'(idx); cfg_sel = SW'(sel); cfg_en = en; cfg_clear = clr;
    tick();
    cfg_wr = 1'b0; cfg_clear = 1'b0;
  endtask

  task automatic pulse(input logic [EW-1:0] mask, input int n);
    events = mask;
    tick(n);
    events = '0;
  endtask

  task automatic rd_chk(input string tag, input int idx, input logic sh, input logic [63:0] exp);
    rd_req = 1'b1; rd_idx = IW'(idx); rd_shadow = sh;
    tick();
    rd_req = 1'b0;
    check_val({tag, "_vld"}, 64'(rd_valid), 64'd1);
    check_val(tag, 64'(rd_data), exp);
    tick();
    check_val({tag, "_vld_drop"}, 64'(rd_valid), 64'd0);
  endtask

  initial begin
    logic [EW-1:0] ev;
    logic [EW-1:0] one;
    one = EW'(1);
    rst = 1'b0; events = '0; global_en = 1'b0; cfg_wr = 1'b0; cfg_idx = '0;
    cfg_sel = '0; cfg_en = 1'b0; cfg_clear = 1'b0; snapshot_req = 1'b0;
    rd_req = 1'b0; rd_idx = '0; rd_shadow = 1'b0;
    tick(2);
    check_val("reset_vld", 64'(rd_valid), 64'd0);
    check_val("reset_data", 64'(rd_data), 64'd0);
    check_val("reset_ovf", 64'(overflow), 64'd0);
    check_val("reset_irq", 64'(overflow_irq), 64'd0);
    rst = 1'b1;
    tick();
    global_en = 1'b1;

    // basic count of ten event cycles
    cfg(0, EV_ALU, 1'b1, 1'b1);
    pulse(one << EV_ALU, 10);
    tick(2);
    rd_chk("basic", 0, 1'b0, 10);

    // one event: counter updates at the edge after the event is captured
    cfg(0, EV_ALU, 1'b1, 1'b1);
    events = one << EV_ALU; rd_req = 1'b1; rd_idx = 0; rd_shadow = 1'b0;
    tick();
    events = '0;
    check_val("lat_capture", 64'(rd_data), 64'd0);
    tick();
    check_val("lat_update_edge", 64'(rd_data), 64'd0);
    tick();
    check_val("lat_after", 64'(rd_data), 64'd1);
    rd_req = 1'b0;
    tick();

    // global_en low freezes counting
    global_en = 1'b0;
    pulse(one << EV_ALU, 20);
    tick(2);
    global_en = 1'b1;
    rd_chk("freeze", 0, 1'b0, 1);

    // select beyond the event width never counts; the top legal index does
    cfg(1, 40, 1'b1, 1'b1);
    cfg(2, 32, 1'b1, 1'b1);
    pulse('1, 5);
    tick(2);
    rd_chk("sel_oor", 1, 1'b0, 0);
    rd_chk("sel_max", 2, 1'b0, 5);

    // wrap at 8 bits, sticky overflow, delayed irq, clear
    cfg(0, EV_ALU, 1'b1, 1'b1);
    pulse(one << EV_ALU, 255);
    tick(2);
    rd_chk("pre_wrap", 0, 1'b0, 255);
    check_val("ovf_pre", 64'(overflow), 64'd0);
    events = one << EV_ALU;
    tick();
    events = '0;
    check_val("ovf_not_yet", 64'(overflow), 64'd0);
    tick();
    check_val("wrap_ovf", 64'(overflow), 64'd1);
    check_val("irq_lag", 64'(overflow_irq), 64'd0);
    tick();
    check_val("irq_set", 64'(overflow_irq), 64'd1);
    rd_chk("wrap_cnt", 0, 1'b0, 0);
    check_val("ovf_sticky", 64'(overflow), 64'd1);
    cfg(0, EV_ALU, 1'b1, 1'b1);
    check_val("ovf_clr", 64'(overflow), 64'd0);
    check_val("irq_hold", 64'(overflow_irq), 64'd1);
    tick();
    check_val("irq_drop", 64'(overflow_irq), 64'd0);

    // snapshot atomicity: counters at 7/9/11/13, events in flight at the request
    for (int k = 0; k < NC; k++) cfg(k, k, 1'b1, 1'b1);
    for (int t = 0; t < 13; t++) begin
      ev = '0;
      for (int k = 0; k < NC; k++) if (t < 7 + 2 * k) ev[k] = 1'b1;
      events = ev;
      tick();
    end
    events = '0;
    tick(2);
    events = EW'(4'hF);
    tick();
    events = '0; snapshot_req = 1'b1;
    tick();
    snapshot_req = 1'b0;
    tick(2);
    for (int k = 0; k < NC; k++) begin
      rd_chk($sformatf("snap_shadow%0d", k), k, 1'b1, 64'(7 + 2 * k));
      rd_chk($sformatf("snap_live%0d", k), k, 1'b0, 64'(8 + 2 * k));
    end

    // collisions: clear beats increment; sel change keeps the old sel for that cycle
    events = one;
    tick();
    events = '0;
    cfg(0, 0, 1'b1, 1'b1);
    tick();
    rd_chk("clr_wins", 0, 1'b0, 0);
    events = one << 1;
    tick();
    events = '0;
    cfg(1, 2, 1'b1, 1'b0);
    tick();
    rd_chk("old_sel", 1, 1'b0, 11);
    pulse(one << 1, 1);
    tick(2);
    rd_chk("old_sel_unbound", 1, 1'b0, 11);
    pulse(one << 2, 1);
    tick(2);
    rd_chk("new_sel", 1, 1'b0, 12);

    // asynchronous reset with a read in flight
    rd_req = 1'b1; rd_idx = 2; rd_shadow = 1'b0;
    tick();
    check_val("rst_pre_vld", 64'(rd_valid), 64'd1);
    check_val("rst_pre_data", 64'(rd_data), 64'd13);
    rst = 1'b0;
    #1;
    check_val("rst_vld", 64'(rd_valid), 64'd0);
    check_val("rst_data", 64'(rd_data), 64'd0);
    check_val("rst_ovf", 64'(overflow), 64'd0);
    check_val("rst_irq", 64'(overflow_irq), 64'd0);
    rd_req = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    check_val("rst_no_vld0", 64'(rd_valid), 64'd0);
    tick();
    check_val("rst_no_vld1", 64'(rd_valid), 64'd0);
    rd_chk("rst_live", 2, 1'b0, 0);
    rd_chk("rst_shadow", 2, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/trace_event_counter_bank.md
Name: trace_event_counter_bank

Overview:
- Programmable performance-counter bank that consumes the per-cycle cva5_trace_events_t vector from the trace outputs.
- Each of NUM_COUNTERS counters is bound at run time to one event bit and counts cycles in which that bit is high.
- Supports an atomic snapshot of all counters into shadow registers, a registered read port for the CSR/debug path, and sticky overflow with an interrupt.

Parameters:
- NUM_COUNTERS, 4, number of counters; 1..16.
- COUNTER_W, 40, counter width in bits; 8..64.
- EVENT_W, $bits(cva5_trace_events_t) (33), number of selectable event bits.
- SEL_W, $clog2(EVENT_W) (6), width of the event-select field.

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous, active-low reset.
- events  in  EVENT_W  cva5_trace_events_t; bit i is event index i, LSB = last struct field (br_is_call).
- global_en  in  1  counting enable for all counters.
- cfg_wr  in  1  configuration write strobe.
- cfg_idx  in  $clog2(NUM_COUNTERS)  target counter of cfg_wr.
- cfg_sel  in  SEL_W  event index bound to the counter.
- cfg_en  in  1  per-counter enable.
- cfg_clear  in  1  zero the counter and its overflow flag.
- snapshot_req  in  1  copy all live counters into the shadows.
- rd_req  in  1  read request.
- rd_idx  in  $clog2(NUM_COUNTERS)  counter to read.
- rd_shadow  in  1  0 = read live value, 1 = read shadow value.
- rd_valid  out  1  read data valid.
- rd_data  out  COUNTER_W  read data.
- overflow  out  NUM_COUNTERS  sticky overflow flags.
- overflow_irq  out  1  OR of (overflow & irq-enable); irq-enable equals per-counter cfg_en.

Behaviour:
- Reset (rst low, asynchronous), everything cleared:
  - all counters, shadows, sel fields, per-counter enables and overflow flags = 0;
  - rd_valid = 0, rd_data = 0, overflow_irq = 0;
  - the event pipeline register = 0.
- Event pipeline:
  - events is registered once (ev_q).
  - Counter k increments in cycle N+1 when events[sel_k] was high in cycle N, en_k = 1, global_en was high in cycle N, and sel_k < EVENT_W.
  - Increment latency is therefore 1 cycle from the event to the counter register update.
  - A sel_k >= EVENT_W never increments.
- Configuration write (cfg_wr = 1), takes effect at the next edge:
  - sel and en of counter cfg_idx are loaded.
  - If cfg_clear = 1, the counter and overflow[cfg_idx] are zeroed. This takes priority over a same-cycle increment of that counter, and the increment is lost.
  - If cfg_clear = 0, the counter value is kept. A same-cycle increment uses the OLD sel and en.
- Wrap-around:
  - A counter at all-ones that increments becomes 0, and overflow[k] is set.
  - overflow[k] is sticky; only cfg_clear or reset clears it.
  - If a clear and a wrap occur in the same cycle, the clear wins.
- Snapshot:
  - snapshot_req copies every live counter into its shadow at the same edge; all counters are captured in the same cycle.
  - Shadows capture the pre-increment value, i.e. the value visible in the cycle of the request.
  - A simultaneous cfg_clear does not affect the shadow captured in that cycle.
- Read port:
  - rd_req in cycle N gives rd_valid = 1 and rd_data in cycle N+1, for exactly one cycle.
  - rd_data is the live or shadow value as sampled in cycle N, i.e. before any cycle-N update.
  - Back-to-back requests are supported every cycle.
  - rd_data holds its last value when rd_valid = 0.
  - rd_idx >= NUM_COUNTERS returns 0 with rd_valid = 1.
- overflow_irq is a registered OR of (overflow[k] & en_k). It asserts 1 cycle after the flag sets.
- global_en low freezes all counting; configuration, snapshot and read remain functional.
- Reset mid-operation clears all state immediately, including any pending read (rd_valid = 0).

Test Plan:
- Basic count: bind counter0 to the alu_op index, en = 1, global_en = 1; drive alu_op high for 10 cycles, then read live → rd_data = 10, rd_valid exactly 1 cycle after rd_req.
- Latency and freeze: event pulse at cycle 5 → counter changes at cycle 6. With global_en = 0, 20 event cycles → counter unchanged.
- Wrap: COUNTER_W = 8; preload via 255 events, then one more event → counter = 0, overflow[0] = 1, overflow_irq = 1 one cycle later. Then cfg_clear → overflow[0] = 0 and irq drops.
- Snapshot atomicity: counters 0..3 at 7, 9, 11, 13 with events active during snapshot_req → shadows read back 7, 9, 11, 13 while live values are +1.
- Collisions: cfg_wr with cfg_clear on the same cycle as an increment → counter = 0. cfg_wr without clear changing sel on an event cycle → increment follows the old sel.
- Async reset: assert rst low mid-count with rd_req pending → all outputs 0 immediately, no rd_valid after release; sel >= 33 never counts.
